frog_input_conditioner: RTL and testbench

- Front end for the four direction switches; drives the frog movement controller's i_Frog_Up/Dn/Lt/Rt inputs.
- Synchronises and debounces raw switches, arbitrates to a single direction and emits one-cycle move strobes.
- Held switch gives one move, or auto-repeat moves when FROG_AUTOREPEAT_EN is defined.
- Sits between the board switch pins and the movement controller; gated by game-active state.

---
 rtl/frog_input_conditioner.sv | 173 +++++++++++++++++
 tb/tb_frog_input_conditioner.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/frog_input_conditioner.sv
// frog_input_conditioner
//   Front end for the four frog direction switches. Each raw switch is
//   synchronised (2 flops) and debounced, the debounced vector is arbitrated
//   down to a single direction, and one-cycle move strobes are issued to the
//   frog movement controller.
//
//   Optional feature macro: FROG_AUTOREPEAT_EN
//     undefined : one strobe per press; the repeat counter is not built.
//     defined   : a held single direction re-strobes after REPEAT_DELAY
//                 cycles, then every REPEAT_PERIOD cycles.
//
//   Ports
//     i_Clk          system clock
//     i_Reset        synchronous, active-high reset
//     i_Switch_*     raw switches (asynchronous to i_Clk)
//     i_Game_Active  high while a game is running
//     o_Frog_*       registered one-cycle move strobes (one-hot or zero)
//     o_Any_Held     registered OR of the debounced switch states
//     o_Move_Count   strobes issued, wraps 255->0

// Per-switch synchroniser + debouncer.
module frog_debounce #(
  parameter int LIMIT = 250000
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Pin,
  output logic o_State
);
  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      o_State <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], i_Pin};
      // sync_q[1] is the raw value; any agreement with the accepted state
      // throws away partial progress, so short glitches never land.
      if (sync_q[1] == o_State) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(LIMIT - 1)) begin
        o_State <= sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
endmodule

module frog_input_conditioner #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int REPEAT_DELAY   = 12500000,
  parameter int REPEAT_PERIOD  = 6250000
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Switch_Up,
  input  logic       i_Switch_Dn,
  input  logic       i_Switch_Lt,
  input  logic       i_Switch_Rt,
  input  logic       i_Game_Active,
  output logic       o_Frog_Up,
  output logic       o_Frog_Dn,
  output logic       o_Frog_Lt,
  output logic       o_Frog_Rt,
  output logic       o_Any_Held,
  output logic [7:0] o_Move_Count
);
  typedef enum logic [1:0] {IDLE, HELD, BLOCKED} state_t;

  // Direction vectors are ordered {Up, Dn, Lt, Rt}.
  logic [3:0] raw_sw, deb;
  logic [3:0] dir_q, dir_d;
  logic [3:0] strobe_q, strobe_d;
  logic       none, single;
  state_t     state_q, state_d;

  assign raw_sw = {i_Switch_Up, i_Switch_Dn, i_Switch_Lt, i_Switch_Rt};

  frog_debounce #(.LIMIT(DEBOUNCE_LIMIT)) u_db [3:0] (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_Pin   (raw_sw),
    .o_State (deb)
  );

  assign none   = (deb == 4'b0000);
  assign single = !none && ((deb & (deb - 4'd1)) == 4'b0000);

`ifdef FROG_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
  logic [RW-1:0] rep_q, rep_d;
`endif

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    strobe_d = 4'b0000;
`ifdef FROG_AUTOREPEAT_EN
    rep_d    = rep_q;
`endif
    case (state_q)
      IDLE: begin
        if (!none) begin
          // A switch already down when the game starts, or a chord, must be
          // released completely before it can count as a press.
          if (!single || !i_Game_Active) begin
            state_d = BLOCKED;
          end else begin
            strobe_d = deb;
            dir_d    = deb;
            state_d  = HELD;
`ifdef FROG_AUTOREPEAT_EN
            rep_d    = RW'(REPEAT_DELAY - 1);
`endif
          end
        end
      end
      HELD: begin
        if ((deb & dir_q) == 4'b0000) begin
          state_d = IDLE;
        end else if (deb != dir_q || !i_Game_Active) begin
          state_d = BLOCKED;
        end else begin
`ifdef FROG_AUTOREPEAT_EN
          if (rep_q == '0) begin
            // Never strobe back-to-back even with a degenerate period.
            strobe_d = dir_q & ~strobe_q;
            rep_d    = RW'(REPEAT_PERIOD - 1);
          end else begin
            rep_d = rep_q - 1'b1;
          end
`endif
        end
      end
      BLOCKED: begin
        if (none) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q      <= IDLE;
      dir_q        <= '0;
      strobe_q     <= '0;
      o_Any_Held   <= 1'b0;
      o_Move_Count <= '0;
`ifdef FROG_AUTOREPEAT_EN
      rep_q        <= '0;
`endif
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      strobe_q   <= strobe_d;
      o_Any_Held <= |deb;
      if (strobe_d != 4'b0000) o_Move_Count <= o_Move_Count + 8'd1;
`ifdef FROG_AUTOREPEAT_EN
      rep_q      <= rep_d;
`endif
    end
  end

  assign {o_Frog_Up, o_Frog_Dn, o_Frog_Lt, o_Frog_Rt} = strobe_q;
endmodule

// File: tb/tb_frog_input_conditioner.sv
module tb_frog_input_conditioner;
  logic       clk = 1'b0;
  logic       rst;
  logic       sw_up, sw_dn, sw_lt, sw_rt, active;
  logic       f_up, f_dn, f_lt, f_rt, any_held;
  logic [7:0] move_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  frog_input_conditioner #(
    .DEBOUNCE_LIMIT(4),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (5)
  ) dut (
    .i_Clk         (clk),
    .i_Reset       (rst),
    .i_Switch_Up   (sw_up),
    .i_Switch_Dn   (sw_dn),
    .i_Switch_Lt   (sw_lt),
    .i_Switch_Rt   (sw_rt),
    .i_Game_Active (active),
    .o_Frog_Up     (f_up),
    .o_Frog_Dn     (f_dn),
    .o_Frog_Lt     (f_lt),
    .o_Frog_Rt     (f_rt),
    .o_Any_Held    (any_held),
    .o_Move_Count  (move_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step one cycle and check the strobe vector {Up,Dn,Lt,Rt}.
  task automatic step_chk(input string tag, input int t, input logic [3:0] exp);
    tick();
    chk($sformatf("%s_t%0d", tag, t), {28'd0, f_up, f_dn, f_lt, f_rt}, {28'd0, exp});
  endtask

  function automatic logic rt_pulse(input int t);
`ifdef FROG_AUTOREPEAT_EN
    return (t == 7 || t == 17 || t == 22 || t == 27 || t == 32 || t == 37 || t == 42);
`else
    return (t == 7);
`endif
  endfunction

  initial begin
    rst = 1'b1; sw_up = 0; sw_dn = 0; sw_lt = 0; sw_rt = 0; active = 1'b1;
    tick(); tick();
    chk("rst_strobes", {28'd0, f_up, f_dn, f_lt, f_rt}, 32'd0);
    chk("rst_any", {31'd0, any_held}, 32'd0);
    chk("rst_cnt", {24'd0, move_cnt}, 32'd0);
    rst = 1'b0;
    tick(); tick();

    // Up glitch of 3 cycles: below debounce limit, never accepted.
    sw_up = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      if (t == 4) sw_up = 1'b0;
      step_chk("glitch", t, 4'b0000);
      chk($sformatf("glitch_any_t%0d", t), {31'd0, any_held}, 32'd0);
    end
    chk("glitch_cnt", {24'd0, move_cnt}, exp_cnt);

    // Lt held 10 cycles: single pulse at cycle 7.
    sw_lt = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      if (t == 11) sw_lt = 1'b0;
      step_chk("lt", t, (t == 7) ? 4'b0010 : 4'b0000);
      if (t == 6) chk("lt_any_before", {31'd0, any_held}, 32'd0);
      if (t == 7) chk("lt_any_after", {31'd0, any_held}, 32'd1);
    end
    exp_cnt += 1;
    chk("lt_cnt", {24'd0, move_cnt}, exp_cnt);
    chk("lt_any_rel", {31'd0, any_held}, 32'd0);

    // Rt held 40 cycles: one pulse, or the auto-repeat train.
    sw_rt = 1'b1;
    for (int t = 1; t <= 55; t++) begin
      if (t == 41) sw_rt = 1'b0;
      step_chk("rt", t, {3'b000, rt_pulse(t)});
    end
`ifdef FROG_AUTOREPEAT_EN
    exp_cnt += 7;
`else
    exp_cnt += 1;
`endif
    chk("rt_cnt", {24'd0, move_cnt}, exp_cnt);

    // Up+Dn chord: blocked, then Dn alone gives one pulse.
    sw_up = 1'b1; sw_dn = 1'b1;
    for (int t = 1; t <= 24; t++) begin
      if (t == 13) begin sw_up = 1'b0; sw_dn = 1'b0; end
      step_chk("chord", t, 4'b0000);
    end
    chk("chord_cnt", {24'd0, move_cnt}, exp_cnt);
    sw_dn = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      if (t == 11) sw_dn = 1'b0;
      step_chk("dn", t, (t == 7) ? 4'b0100 : 4'b0000);
    end
    exp_cnt += 1;
    chk("dn_cnt", {24'd0, move_cnt}, exp_cnt);

    // Dn held before game start: no move until released and re-pressed.
    active = 1'b0; sw_dn = 1'b1;
    for (int t = 1; t <= 30; t++) begin
      if (t == 11) begin
        chk("inact_any", {31'd0, any_held}, 32'd1);
        active = 1'b1;
      end
      if (t == 21) sw_dn = 1'b0;
      step_chk("inact", t, 4'b0000);
    end
    chk("inact_cnt", {24'd0, move_cnt}, exp_cnt);
    sw_dn = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      if (t == 11) sw_dn = 1'b0;
      step_chk("repress", t, (t == 7) ? 4'b0100 : 4'b0000);
    end
    exp_cnt += 1;
    chk("repress_cnt", {24'd0, move_cnt}, exp_cnt);

    // Reset while in HELD: outputs clear, then one fresh strobe 7 cycles on.
    sw_up = 1'b1;
    for (int t = 1; t <= 8; t++) step_chk("pre_rst", t, (t == 7) ? 4'b1000 : 4'b0000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_strobes", {28'd0, f_up, f_dn, f_lt, f_rt}, 32'd0);
    chk("midrst_any", {31'd0, any_held}, 32'd0);
    chk("midrst_cnt", {24'd0, move_cnt}, 32'd0);
    for (int t = 1; t <= 20; t++) begin
      if (t == 11) sw_up = 1'b0;
      step_chk("post_rst", t, (t == 7) ? 4'b1000 : 4'b0000);
    end
    chk("post_rst_cnt", {24'd0, move_cnt}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
